// File: rtl/muldiv_unit_if.sv
// HI/LO writer interface between the pipeline and the iterative multiply/divide unit.
// start/op/a/b are sampled on the rising edge while the unit is idle or done; busy marks the
// window where requests are ignored, and done/hi_we/lo_we pulse for one cycle with results.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [1:0]  fsm_state;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi_we, lo_we, hi_out, lo_out, fsm_state
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi_we, lo_we, hi_out, lo_out, fsm_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit on unsigned magnitudes, with one sign-fixup
// cycle that registers HI/LO and a one-cycle DONE state that strobes the HI/LO writes.
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic        is_div;
    logic        sign_a;
    logic        neg_res;
    logic        b_zero;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] acc;
    logic [4:0]  cnt;

    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign accept    = bus.start && (state == S_IDLE || state == S_DONE);
    assign signed_op = ~bus.op[0];
    assign a_mag     = (signed_op && bus.a[31]) ? -bus.a : bus.a;
    assign b_mag     = (signed_op && bus.b[31]) ? -bus.b : bus.b;

    // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
    assign mul_sum   = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);

    // Divide: remainder lives in acc[63:32], quotient shifts into acc[31:0].
    // The partial remainder is always below twice the divisor, so bit 32 of the trial is the borrow.
    assign rem_shift = {acc[63:32], opa[31]};
    assign trial     = rem_shift - {1'b0, opb};
    assign q_bit     = ~trial[32];
    assign rem_nxt   = q_bit ? trial[31:0] : rem_shift[31:0];

    // A zero divisor yields an all-ones quotient and |a| as remainder; restoring the sign of a
    // reproduces a exactly, so only the quotient negation needs suppressing.
    assign prod_fix  = neg_res ? -acc : acc;
    assign quo_fix   = (neg_res && !b_zero) ? -acc[31:0] : acc[31:0];
    assign rem_fix   = sign_a ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.cancel)          state_nxt = S_IDLE;
                else if (cnt == 5'd31)   state_nxt = S_FIX;
            end
            S_FIX: begin
                state_nxt = bus.cancel ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_nxt = bus.start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.fsm_state = state;
        case (state)
            S_RUN, S_FIX: bus.busy = 1'b1;
            S_DONE: begin
                bus.done  = 1'b1;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div     <= 1'b0;
            sign_a     <= 1'b0;
            neg_res    <= 1'b0;
            b_zero     <= 1'b0;
            opa        <= 32'd0;
            opb        <= 32'd0;
            acc        <= 64'd0;
            cnt        <= 5'd0;
            bus.hi_out <= 32'd0;
            bus.lo_out <= 32'd0;
        end else begin
            if (accept) begin
                is_div  <= bus.op[1];
                sign_a  <= signed_op & bus.a[31];
                neg_res <= signed_op & (bus.a[31] ^ bus.b[31]);
                b_zero  <= (bus.b == 32'd0);
                opa     <= a_mag;
                opb     <= b_mag;
                acc     <= 64'd0;
                cnt     <= 5'd0;
            end else if (state == S_RUN) begin
                cnt <= cnt + 5'd1;
                if (is_div) begin
                    acc <= {rem_nxt, acc[30:0], q_bit};
                    opa <= {opa[30:0], 1'b0};
                end else begin
                    acc <= {mul_sum, acc[31:1]};
                    opb <= {1'b0, opb[31:1]};
                end
            end

            if (state == S_FIX && !bus.cancel) begin
                if (is_div) begin
                    bus.hi_out <= rem_fix;
                    bus.lo_out <= quo_fix;
                end else begin
                    bus.hi_out <= prod_fix[63:32];
                    bus.lo_out <= prod_fix[31:0];
                end
            end
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that produces the HI/LO register pair for MULT, MULTU, DIV and DIVU. It is the writer side of the HI/LO interface that the decode stage reads. It accepts a request with a start/busy handshake, computes over 32 iterations, and delivers one-cycle write strobes with the HI and LO results. It sits beside the execute stage; the pipeline stalls HI/LO readers while `busy` is high.

## Interface
Parameters:
- none (width fixed at 32, iteration count fixed at 32)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when unit is idle or in DONE
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start
- a  input  32  multiplicand / dividend (rs value); sampled with start
- b  input  32  multiplier / divisor (rt value); sampled with start
- cancel  input  1  pipeline flush; aborts an operation in flight
- busy  output  1  high while RUN or FIX
- done  output  1  one-cycle pulse; results valid
- hi_we  output  1  HI write strobe; equals done
- lo_we  output  1  LO write strobe; equals done
- hi_out  output  32  HI result (product[63:32] or remainder)
- lo_out  output  32  LO result (product[31:0] or quotient)

## Operation
- States: IDLE, RUN, FIX, DONE. Reset value: IDLE, and busy, done, hi_we and lo_we are 0. hi_out and lo_out reset to 0.
- Accept: start=1 in IDLE or DONE causes the following on that edge:
  - latch |a| and |b|, using magnitude for signed ops and raw values for unsigned;
  - latch the sign flags and op;
  - clear the 64-bit accumulator;
  - set the iteration counter to 0;
  - go to RUN.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first. The 64-bit accumulator holds the unsigned magnitude product.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. A 33-bit trial subtraction is used. The remainder and quotient build up in the accumulator.
- RUN lasts exactly 32 cycles (counter 0..31), then moves to FIX.
- FIX (1 cycle) applies the sign correction and registers the results into hi_out/lo_out:
  - MULT: negate the 64-bit product if sign(a) XOR sign(b).
  - DIV: negate the quotient if sign(a) XOR sign(b); give the remainder the sign of a.
- DONE (1 cycle): done, hi_we and lo_we are 1. The next state is RUN if start=1, otherwise IDLE.
- Divide by zero (b=0, DIV or DIVU): bypass the signed fixup. Result is lo_out=32'hFFFFFFFF and hi_out=a. Latency is unchanged.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000 and hi_out=0. This falls out of the magnitude algorithm and needs no special case.
- start while busy: ignored. No queuing, and operands are not re-sampled.
- cancel in RUN or FIX: go to IDLE on the next edge. done, hi_we and lo_we are not asserted. hi_out and lo_out keep their previous values.
- cancel in IDLE or DONE: no effect. The DONE-cycle strobes still fire.
- start and cancel in the same cycle: cancel wins if busy. If not busy, start is accepted and cancel is ignored.
- rst at any time, including mid-operation: go to IDLE; all outputs return to reset values on that edge.

## Timing
- start is sampled at edge E0.
- busy=1 after E0 through edge E33: RUN covers E1..E32 and FIX is E33.
- done, hi_we and lo_we are high for the single cycle following E33, i.e. they are sampled high by the consumer at E34.
- Total latency is 34 cycles from start sample to the HI/LO write edge, identical for all ops and operand values.
- hi_out and lo_out are registered. They are stable from the DONE cycle until the next FIX completes.
- Back-to-back: start during DONE gives busy=1 in the very next cycle. Throughput is one op per 34 cycles.
- No combinational path from inputs to outputs.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34; hi_out=0xFFFFFFFE, lo_out=0x00000001; hi_we=lo_we=1 for exactly one cycle.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- DIVU a=7, b=0 -> lo_out=0xFFFFFFFF, hi_out=0x00000007, latency 34. DIV a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Start DIVU 100/7. Pulse start with different operands at cycle 5 (ignored). Assert cancel at cycle 10 -> busy drops at cycle 11, no done, hi_out/lo_out unchanged. A new MULTU 6*7 then gives lo_out=42, hi_out=0.
- Back-to-back: start asserted during the DONE cycle of MULTU 3*4 with DIVU 9/2 -> first done gives lo=12, hi=0. The second done arrives 34 cycles later with lo=4, hi=1. busy is low only during the DONE cycle.
- Assert rst at cycle 20 of a MULT -> next cycle busy=0, done=0, hi_out=lo_out=0; no strobe ever issued for that op.
